// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the lfsr_stream generator.
//   lfsr_mode_e   - feedback structure (FIBONACCI / GALOIS)
//   lock_state_e  - lockup FSM states (RUN / LOCKED / RECOVER)
//   width_ok()    - legal state width check (3..32)
//   steps_ok()    - legal shifts-per-advance check (1..WIDTH)
//   max_taps()    - maximal-length tap mask for widths 3..32, bit i set means
//                   state bit i participates in the feedback
package lfsr_pkg;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOCKED  = 2'd1,
    RECOVER = 2'd2
  } lock_state_e;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  function automatic bit steps_ok(input int s, input int w);
    return (s >= 1) && (s <= w);
  endfunction

  // Tap positions in the usual 1-based polynomial notation (x^n -> bit n-1).
  function automatic logic [31:0] tap_bit(input int n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic logic [31:0] max_taps(input int width);
    logic [31:0] t;
    case (width)
      3:       t = tap_bit(3)  | tap_bit(2);
      4:       t = tap_bit(4)  | tap_bit(3);
      5:       t = tap_bit(5)  | tap_bit(3);
      6:       t = tap_bit(6)  | tap_bit(5);
      7:       t = tap_bit(7)  | tap_bit(6);
      8:       t = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:       t = tap_bit(9)  | tap_bit(5);
      10:      t = tap_bit(10) | tap_bit(7);
      11:      t = tap_bit(11) | tap_bit(9);
      12:      t = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13:      t = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14:      t = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15:      t = tap_bit(15) | tap_bit(14);
      16:      t = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17:      t = tap_bit(17) | tap_bit(14);
      18:      t = tap_bit(18) | tap_bit(11);
      19:      t = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20:      t = tap_bit(20) | tap_bit(17);
      21:      t = tap_bit(21) | tap_bit(19);
      22:      t = tap_bit(22) | tap_bit(21);
      23:      t = tap_bit(23) | tap_bit(18);
      24:      t = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25:      t = tap_bit(25) | tap_bit(22);
      26:      t = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27:      t = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28:      t = tap_bit(28) | tap_bit(25);
      29:      t = tap_bit(29) | tap_bit(27);
      30:      t = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31:      t = tap_bit(31) | tap_bit(28);
      32:      t = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR shift.
//   i_state  [WIDTH] current state
//   i_taps   [WIDTH] tap mask (bit i set = state bit i participates)
//   i_mode           FIBONACCI: shift left, feed XOR of tapped bits into bit 0
//                    GALOIS:    shift left, XOR taps in when the MSB falls out
//   o_state  [WIDTH] state after one shift
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  input  lfsr_mode_e       i_mode,
  output logic [WIDTH-1:0] o_state
);

  logic             w_fb;
  logic [WIDTH-1:0] w_shift;

  assign w_fb    = ^(i_state & i_taps);
  assign w_shift = {i_state[WIDTH-2:0], 1'b0};

  always_comb begin
    if (i_mode == GALOIS) begin
      o_state = w_shift ^ (i_state[WIDTH-1] ? i_taps : '0);
    end else begin
      o_state = {i_state[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: runtime-configurable LFSR presented as a valid/ready stream.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                run enable; out_valid is low while en is low
//   seed_load/_data   load state and seed register (advance that cycle dropped)
//   taps_we/_data     load the tap mask (the advance that cycle uses old taps)
//   out_valid/_ready  stream handshake; out_data is the current state
//   wrap              one-cycle pulse when an advance returns to the seed
//   period            beats between the last two wraps (0 until first wrap)
//   lockup            state is all-zero
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter logic [WIDTH-1:0] DEF_TAPS     = 10'h3FC,
  parameter int               MODE         = 0,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] RESET_SEED   = WIDTH'(1),
  parameter bit               AUTO_RECOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             taps_we,
  input  logic [WIDTH-1:0] taps_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be within 3..32");
  end
  if (!steps_ok(STEPS, WIDTH)) begin : g_bad_steps
    $error("lfsr_stream: STEPS must be within 1..WIDTH");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_stream: RESET_SEED must be nonzero");
  end

  localparam lfsr_mode_e LP_MODE = (MODE == 1) ? GALOIS : FIBONACCI;

  logic [WIDTH-1:0] r_state, r_seed, r_taps, r_cnt, r_period;
  logic             r_wrap;
  lock_state_e      r_lock, w_lock_nxt;

  logic [WIDTH-1:0] w_state_nxt, w_seed_nxt, w_cnt_nxt, w_period_nxt;
  logic             w_wrap_nxt, w_fire;
  logic [WIDTH-1:0] w_adv;

  // STEPS single shifts chained within one cycle.
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [WIDTH-1:0] w_in, w_out;
    if (g == 0) begin : g_first
      assign w_in = r_state;
    end else begin : g_next
      assign w_in = g_step[g-1].w_out;
    end
    lfsr_step #(.WIDTH(WIDTH)) u_step (
      .i_state (w_in),
      .i_taps  (r_taps),
      .i_mode  (LP_MODE),
      .o_state (w_out)
    );
  end
  assign w_adv = g_step[STEPS-1].w_out;

  // rst_n gates valid directly so it drops the moment reset is applied.
  assign out_valid = en & rst_n & (r_lock == RUN);
  assign w_fire    = out_valid & out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_seed_nxt   = r_seed;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_wrap_nxt   = 1'b0;
    // An explicit seed load wins over automatic recovery and over advancing.
    if (seed_load) begin
      w_state_nxt = seed_data;
      w_seed_nxt  = seed_data;
      w_cnt_nxt   = '0;
    end else if (r_lock == RECOVER) begin
      w_state_nxt = RESET_SEED;
      w_seed_nxt  = RESET_SEED;
      w_cnt_nxt   = '0;
    end else if (w_fire) begin
      w_state_nxt = w_adv;
      if (w_adv == r_seed) begin
        w_wrap_nxt   = 1'b1;
        w_period_nxt = r_cnt + WIDTH'(1);
        w_cnt_nxt    = '0;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end
    // Lockup tracks the state register: the FSM leaves RUN whenever the state
    // about to be stored is all-zero, and returns once it is nonzero again.
    w_lock_nxt = RUN;
    if (w_state_nxt == '0) begin
      w_lock_nxt = AUTO_RECOVER ? RECOVER : LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= RUN;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RESET_SEED;
      r_seed   <= RESET_SEED;
      r_taps   <= DEF_TAPS;
      r_cnt    <= '0;
      r_period <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_seed   <= w_seed_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_wrap   <= w_wrap_nxt;
      if (taps_we) begin
        r_taps <= taps_data;
      end
    end
  end

  assign out_data = r_state;
  assign wrap     = r_wrap;
  assign period   = r_period;
  assign lockup   = (r_lock != RUN);

endmodule

// File: tb/tb_lfsr_stream.sv
`timescale 1ns/1ps
module tb_lfsr_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, out_ready = 1'b0, seed_load = 1'b0, taps_we = 1'b0;
  logic [3:0] seed_data = 4'h0, taps_data = 4'h0;
  logic [9:0] seed_data10 = 10'h0, taps_data10 = 10'h0;

  // Instances 0..2 are 4-bit: 0 = Fibonacci STEPS=1, 1 = Fibonacci STEPS=2,
  // 2 = Galois taps 3 with AUTO_RECOVER=0. Instance d is the default 10-bit.
  logic [2:0][3:0] o_data, o_per;
  logic [2:0]      o_vld, o_wrap, o_lock;
  logic [9:0]      d_data, d_per;
  logic            d_vld, d_wrap, d_lock;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_stream #(.WIDTH(4), .DEF_TAPS(4'hC), .MODE(0), .STEPS(1), .RESET_SEED(4'h1), .AUTO_RECOVER(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .taps_we(taps_we), .taps_data(taps_data), .out_valid(o_vld[0]), .out_ready(out_ready),
    .out_data(o_data[0]), .wrap(o_wrap[0]), .period(o_per[0]), .lockup(o_lock[0]));

  lfsr_stream #(.WIDTH(4), .DEF_TAPS(4'hC), .MODE(0), .STEPS(2), .RESET_SEED(4'h1), .AUTO_RECOVER(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .taps_we(taps_we), .taps_data(taps_data), .out_valid(o_vld[1]), .out_ready(out_ready),
    .out_data(o_data[1]), .wrap(o_wrap[1]), .period(o_per[1]), .lockup(o_lock[1]));

  lfsr_stream #(.WIDTH(4), .DEF_TAPS(4'h3), .MODE(1), .STEPS(1), .RESET_SEED(4'h1), .AUTO_RECOVER(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .taps_we(taps_we), .taps_data(taps_data), .out_valid(o_vld[2]), .out_ready(out_ready),
    .out_data(o_data[2]), .wrap(o_wrap[2]), .period(o_per[2]), .lockup(o_lock[2]));

  lfsr_stream u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_data(seed_data10),
    .taps_we(taps_we), .taps_data(taps_data10), .out_valid(d_vld), .out_ready(out_ready),
    .out_data(d_data), .wrap(d_wrap), .period(d_per), .lockup(d_lock));

  // Expected sequences straight from the reference tables.
  logic [3:0] seq_a[16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] seq_b[16] = '{4'h1, 4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8,
                            4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};
  logic [9:0] seq_d[6]  = '{10'h001, 10'h002, 10'h004, 10'h009, 10'h013, 10'h027};
  logic [3:0] seq_g[4]  = '{4'h3, 4'h6, 4'hC, 4'hB};

  // Behavioural reference for the three 4-bit instances.
  int         p_steps[3] = '{1, 2, 1};
  logic       p_gal[3]   = '{1'b0, 1'b0, 1'b1};
  logic       p_ar[3]    = '{1'b1, 1'b1, 1'b0};
  logic [3:0] p_taps[3]  = '{4'hC, 4'hC, 4'h3};
  logic [3:0] m_st[3], m_seed[3], m_taps[3], m_cnt[3], m_per[3];
  logic       m_wrap[3], m_lock[3];

  function automatic logic [3:0] ref_step(input logic [3:0] s, input logic [3:0] t, input logic gal);
    int v;
    v = (int'(s) * 2) % 16;
    if (gal) begin
      if (s >= 4'd8) v = v ^ int'(t);
    end else begin
      v = v + ($countones(s & t) % 2);
    end
    return 4'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 4'h1; m_seed[k] = 4'h1; m_taps[k] = p_taps[k];
      m_cnt[k] = 4'h0; m_per[k] = 4'h0; m_wrap[k] = 1'b0; m_lock[k] = 1'b0;
    end
  endtask

  task automatic model_clock();
    logic [3:0] s;
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 1'b0;
      if (seed_load) begin
        m_st[k] = seed_data; m_seed[k] = seed_data; m_cnt[k] = 4'h0;
      end else if (m_lock[k] && p_ar[k]) begin
        m_st[k] = 4'h1; m_seed[k] = 4'h1; m_cnt[k] = 4'h0;
      end else if (en && out_ready && !m_lock[k]) begin
        s = m_st[k];
        for (int j = 0; j < p_steps[k]; j++) s = ref_step(s, m_taps[k], p_gal[k]);
        m_st[k] = s;
        if (s == m_seed[k]) begin
          m_wrap[k] = 1'b1; m_per[k] = m_cnt[k] + 4'd1; m_cnt[k] = 4'h0;
        end else begin
          m_cnt[k] = m_cnt[k] + 4'd1;
        end
      end
      if (taps_we) m_taps[k] = taps_data;
      m_lock[k] = (m_st[k] == 4'h0);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; seed_load = 1'b0; taps_we = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (o_data[0] !== 4'h1) begin n_fail++; $display("FAIL reset_data: got %h want 1", o_data[0]); end
    n_chk++; if (o_vld[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_vld[0]); end
    n_chk++; if (o_per[0] !== 4'h0) begin n_fail++; $display("FAIL reset_period: got %h want 0", o_per[0]); end
    n_chk++; if (o_wrap[0] !== 1'b0 || o_lock[0] !== 1'b0) begin n_fail++; $display("FAIL reset_flags: wrap %b lock %b want 0 0", o_wrap[0], o_lock[0]); end
    n_chk++; if (d_data !== 10'h001 || d_vld !== 1'b0 || d_wrap !== 1'b0 || d_lock !== 1'b0) begin
      n_fail++; $display("FAIL reset_d: data %h vld %b wrap %b lock %b want 001 0 0 0", d_data, d_vld, d_wrap, d_lock);
    end
    rst_n = 1'b1;
    #1;
    n_chk++; if (o_vld[0] !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %b want 1", o_vld[0]); end
  endtask

  task automatic test_fib_seq();
    en = 1'b1; out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (o_data[0] !== seq_a[i]) begin n_fail++; $display("FAIL fib1_data[%0d]: got %h want %h", i, o_data[0], seq_a[i]); end
      n_chk++; if (o_data[1] !== seq_b[i]) begin n_fail++; $display("FAIL fib2_data[%0d]: got %h want %h", i, o_data[1], seq_b[i]); end
      n_chk++; if (o_wrap[0] !== (i == 15)) begin n_fail++; $display("FAIL fib1_wrap[%0d]: got %b want %b", i, o_wrap[0], (i == 15)); end
      n_chk++; if (o_wrap[1] !== (i == 15)) begin n_fail++; $display("FAIL fib2_wrap[%0d]: got %b want %b", i, o_wrap[1], (i == 15)); end
      if (i < 6) begin
        n_chk++; if (d_data !== seq_d[i]) begin n_fail++; $display("FAIL w10_data[%0d]: got %h want %h", i, d_data, seq_d[i]); end
      end
    end
    n_chk++; if (o_per[0] !== 4'd15) begin n_fail++; $display("FAIL fib1_period: got %0d want 15", o_per[0]); end
    n_chk++; if (o_per[1] !== 4'd15) begin n_fail++; $display("FAIL fib2_period: got %0d want 15", o_per[1]); end
    @(posedge clk); #1;
    n_chk++; if (o_wrap[0] !== 1'b0 || o_data[0] !== 4'h2) begin
      n_fail++; $display("FAIL fib1_after_wrap: wrap %b data %h want 0 2", o_wrap[0], o_data[0]);
    end
  endtask

  task automatic test_backpressure();
    en = 1'b1; out_ready = 1'b1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o_data[0] !== 4'h9) begin n_fail++; $display("FAIL bp_reach9: got %h want 9", o_data[0]); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (o_data[0] !== 4'h9 || o_vld[0] !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: data %h vld %b want 9 1", i, o_data[0], o_vld[0]);
      end
    end
    out_ready = 1'b1;
    for (int i = 4; i < 16; i++) begin
      @(posedge clk); #1;
      n_chk++; if (o_data[0] !== seq_a[i]) begin n_fail++; $display("FAIL bp_resume[%0d]: got %h want %h", i, o_data[0], seq_a[i]); end
    end
    n_chk++; if (o_wrap[0] !== 1'b1 || o_per[0] !== 4'd15) begin
      n_fail++; $display("FAIL bp_period: wrap %b period %0d want 1 15", o_wrap[0], o_per[0]);
    end
  endtask

  task automatic test_galois();
    en = 1'b1; out_ready = 1'b1;
    apply_reset();
    @(posedge clk); #1;
    seed_load = 1'b1; seed_data = 4'h8;
    @(posedge clk); #1;
    seed_load = 1'b0;
    n_chk++; if (o_data[2] !== 4'h8) begin n_fail++; $display("FAIL gal_seed: got %h want 8", o_data[2]); end
    n_chk++; if (o_data[0] !== 4'h8) begin n_fail++; $display("FAIL load_drops_adv: got %h want 8", o_data[0]); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++; if (o_data[2] !== seq_g[i]) begin n_fail++; $display("FAIL gal_data[%0d]: got %h want %h", i, o_data[2], seq_g[i]); end
    end
    seed_load = 1'b1; seed_data = 4'h8; taps_we = 1'b1; taps_data = 4'h9;
    @(posedge clk); #1;
    seed_load = 1'b0; taps_we = 1'b0;
    n_chk++; if (o_data[2] !== 4'h8 || o_data[0] !== 4'h8) begin
      n_fail++; $display("FAIL both_load: gal %h fib %h want 8 8", o_data[2], o_data[0]);
    end
    @(posedge clk); #1;
    n_chk++; if (o_data[2] !== 4'h9) begin n_fail++; $display("FAIL gal_newtaps: got %h want 9", o_data[2]); end
    n_chk++; if (o_data[0] !== 4'h1) begin n_fail++; $display("FAIL fib_newtaps: got %h want 1", o_data[0]); end
  endtask

  task automatic test_lockup();
    en = 1'b1; out_ready = 1'b1;
    apply_reset();
    seed_load = 1'b1; seed_data = 4'h0;
    @(posedge clk); #1;
    seed_load = 1'b0;
    n_chk++; if (o_lock[0] !== 1'b1 || o_vld[0] !== 1'b0 || o_data[0] !== 4'h0) begin
      n_fail++; $display("FAIL lock_enter: lock %b vld %b data %h want 1 0 0", o_lock[0], o_vld[0], o_data[0]);
    end
    n_chk++; if (o_lock[2] !== 1'b1) begin n_fail++; $display("FAIL lock_enter_noar: got %b want 1", o_lock[2]); end
    @(posedge clk); #1;
    n_chk++; if (o_lock[0] !== 1'b0 || o_vld[0] !== 1'b1 || o_data[0] !== 4'h1) begin
      n_fail++; $display("FAIL lock_recover: lock %b vld %b data %h want 0 1 1", o_lock[0], o_vld[0], o_data[0]);
    end
    n_chk++; if (o_lock[2] !== 1'b1 || o_data[2] !== 4'h0) begin
      n_fail++; $display("FAIL lock_hold1: lock %b data %h want 1 0", o_lock[2], o_data[2]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o_lock[2] !== 1'b1 || o_vld[2] !== 1'b0) begin
      n_fail++; $display("FAIL lock_hold2: lock %b vld %b want 1 0", o_lock[2], o_vld[2]);
    end
    seed_load = 1'b1; seed_data = 4'h5;
    @(posedge clk); #1;
    seed_load = 1'b0;
    n_chk++; if (o_data[2] !== 4'h5 || o_lock[2] !== 1'b0) begin
      n_fail++; $display("FAIL lock_exit: data %h lock %b want 5 0", o_data[2], o_lock[2]);
    end
    taps_we = 1'b1; taps_data = 4'h0;
    @(posedge clk); #1;
    taps_we = 1'b0;
    n_chk++; if (o_data[2] !== 4'hA) begin n_fail++; $display("FAIL old_taps_adv: got %h want a", o_data[2]); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o_lock[2] !== 1'b1 || o_data[2] !== 4'h0) begin
      n_fail++; $display("FAIL gal_zero_taps: lock %b data %h want 1 0", o_lock[2], o_data[2]);
    end
  endtask

  task automatic test_reset_midstream();
    en = 1'b1; out_ready = 1'b1;
    apply_reset();
    repeat (15) @(posedge clk);
    #1;
    n_chk++; if (o_per[0] !== 4'd15) begin n_fail++; $display("FAIL mid_period: got %0d want 15", o_per[0]); end
    repeat (6) @(posedge clk);
    #1;
    n_chk++; if (o_data[0] !== 4'hD) begin n_fail++; $display("FAIL mid_reachD: got %h want d", o_data[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (o_data[0] !== 4'h1 || o_vld[0] !== 1'b0 || o_per[0] !== 4'h0) begin
      n_fail++; $display("FAIL mid_async: data %h vld %b period %h want 1 0 0", o_data[0], o_vld[0], o_per[0]);
    end
    n_chk++; if (d_data !== 10'h001 || d_per !== 10'h000) begin
      n_fail++; $display("FAIL mid_async_d: data %h period %h want 001 000", d_data, d_per);
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      seed_load = ($urandom % 24) == 0;
      seed_data = 4'($urandom % 16);
      taps_we   = ($urandom % 24) == 0;
      taps_data = 4'($urandom % 16);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++; if (o_vld[k] !== (en && !m_lock[k])) begin
          n_fail++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, c, o_vld[k], (en && !m_lock[k]));
        end
      end
      model_clock();
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++; if (o_data[k] !== m_st[k]) begin n_fail++; $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", k, c, o_data[k], m_st[k]); end
        n_chk++; if (o_wrap[k] !== m_wrap[k]) begin n_fail++; $display("FAIL rnd_wrap[%0d] cyc %0d: got %b want %b", k, c, o_wrap[k], m_wrap[k]); end
        n_chk++; if (o_per[k] !== m_per[k]) begin n_fail++; $display("FAIL rnd_period[%0d] cyc %0d: got %h want %h", k, c, o_per[k], m_per[k]); end
        n_chk++; if (o_lock[k] !== m_lock[k]) begin n_fail++; $display("FAIL rnd_lock[%0d] cyc %0d: got %b want %b", k, c, o_lock[k], m_lock[k]); end
      end
    end
    seed_load = 1'b0; taps_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fib_seq();
    test_backpressure();
    test_galois();
    test_lockup();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
Parametrised LFSR generator for pseudo-random stimulus and scrambling in the lab designs.
- Width, tap mask, structure (Fibonacci or Galois) and shifts-per-advance are configurable.
- Taps and seed are runtime-loadable.
- Output is a valid/ready stream, with all-zero lockup detection/recovery and sequence-wrap (period) reporting.

Parameters:
WIDTH, 10, state width (3..32)
DEF_TAPS, 10'h3FC, tap mask loaded at reset (bit i set = state bit i participates)
MODE, 0, 0 = Fibonacci, 1 = Galois
STEPS, 1, single-shifts applied per accepted beat (1..WIDTH)
RESET_SEED, 1, state and seed register value at reset (must be nonzero)
AUTO_RECOVER, 1, 1 = reload RESET_SEED automatically on lockup

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; gates out_valid
seed_load  in  1  load seed_data into state and seed register
seed_data  in  WIDTH  seed value
taps_we  in  1  load taps_data into tap register
taps_data  in  WIDTH  new tap mask
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  consumer accepts beat
out_data  out  WIDTH  current LFSR state
wrap  out  1  one-cycle pulse: accepted advance returned state to seed register
period  out  WIDTH  beats between last two wraps (0 until first wrap)
lockup  out  1  state is all-zero

Behaviour:
- Reset (async, rst_n=0):
  - state = seed_reg = RESET_SEED; taps = DEF_TAPS.
  - beat counter = 0, period = 0, wrap = 0, lockup = 0; out_valid = 0.
  - out_valid is combinational: en && !lockup.
- Single step f(s):
  - Fibonacci: fb = XOR-reduce(s & taps); s' = {s[WIDTH-2:0], fb}.
  - Galois: s' = {s[WIDTH-2:0], 0} XOR (s[WIDTH-1] ? taps : 0).
- Advance: on a cycle with out_valid && out_ready, state <= f^STEPS(state) (STEPS chained steps, same cycle). Beat counter +1.
- Latency: out_data reflects the new state the cycle after acceptance. No bubbles, so one beat per cycle at full ready.
- Backpressure: out_valid high with out_ready low leaves state and out_data stable.
- en low: out_valid = 0, state frozen. Loads are still honoured.
- Wrap detection:
  - Applies when an advance produces state == seed_reg.
  - wrap = 1 for exactly one cycle (registered, coincident with out_data showing the new state).
  - period <= beat counter + 1; beat counter <= 0.
- Counter overflow: the beat counter wraps modulo 2^WIDTH; no flag.
- seed_load:
  - state <= seed_data, seed_reg <= seed_data, beat counter <= 0, wrap = 0.
  - period is kept; any advance that cycle is discarded.
- taps_we: taps <= taps_data next cycle. The state advance that cycle uses the old taps. Counter unaffected.
- Simultaneous seed_load and taps_we: both take effect; no advance.
- Lockup:
  - lockup = (state == 0), registered with state.
  - AUTO_RECOVER=1: the cycle after lockup asserts, state <= RESET_SEED, seed_reg <= RESET_SEED, counter <= 0. Lockup is therefore high for exactly one cycle.
  - AUTO_RECOVER=0: lockup holds until seed_load with a nonzero value.
  - seed_load of zero enters lockup.
- Galois with taps = 0 shifts to zero, then lockup (legal, covered).
- Reset mid-stream: all registers return to reset values immediately (async). out_valid drops in the same cycle.

Decomposition:
- Package lfsr_pkg:
  - mode constants FIBONACCI/GALOIS
  - maximal-length tap table function max_taps(width) for widths 3..32
  - WIDTH/STEPS legality checks
- Sub-module lfsr_step: purely combinational single step (inputs state, taps, mode). lfsr_stream instantiates STEPS copies in a chain via generate.
- The top holds registers, handshake, wrap/period counter and lockup FSM. The FSM has states RUN, LOCKED, RECOVER.

Test Plan:
- Fibonacci, WIDTH=4, DEF_TAPS=4'hC, RESET_SEED=1, en=1, out_ready=1 -> out_data 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1; wrap pulses once on return to 1; period=15.
- Same config, STEPS=2 -> out_data 1,4,3,D,5,7,E,8,2,9,6,A,B,F,C,1; period=15.
- Backpressure: out_ready low for 3 cycles at state 9 -> out_data holds 9, no advance, counter frozen; resumes to 3 on ready.
- Galois, WIDTH=4, taps=4'h3, seed_load 4'h8 -> next out_data 3, then 6, then C, then B. seed_load and taps_we asserted in the same cycle -> no advance, both values take effect next cycle.
- Lockup: seed_load 0 with AUTO_RECOVER=1 -> lockup=1 and out_valid=0 for one cycle, then out_data=RESET_SEED=1. With AUTO_RECOVER=0 -> lockup holds until seed_load 5, then out_data=5.
- Async reset asserted mid-stream at state D -> out_data=1, out_valid=0, period=0 immediately, without waiting for a clock edge. Default 10-bit config from 1 yields 002,004,009,013,027.
